// File: rtl/add_serial_feeder_if.sv
// Stream and adder-side signal bundle for the operand feeder.
// master is the feeder side, slave is the producer/adder/consumer side.
interface add_serial_feeder_if #(
   parameter int W = 8
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         add_en;
   logic [W-1:0] add_a;
   logic [W-1:0] add_b;
   logic [W-1:0] add_out;
   logic         res_valid;
   logic         res_ready;
   logic [W-1:0] res_sum;
   logic         busy;
   logic [7:0]   op_cnt;

   modport master (
      input  in_valid, in_a, in_b, add_out, res_ready,
      output in_ready, add_en, add_a, add_b,
      output res_valid, res_sum, busy, op_cnt
   );

   modport slave (
      output in_valid, in_a, in_b, add_out, res_ready,
      input  in_ready, add_en, add_a, add_b,
      input  res_valid, res_sum, busy, op_cnt
   );
endinterface

// File: rtl/add_serial_feeder.sv
// Operand FIFO and sequencer around the bit-serial adder: one op in
// flight, fixed-latency capture, result held until accepted.
module add_serial_feeder #(
   parameter int DEPTH   = 4,
   parameter int LATENCY = 10,
   parameter int W       = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   add_serial_feeder_if.master   bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(LATENCY + 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] LAUNCH  = 2'd1;
   localparam logic [1:0] WAIT    = 2'd2;
   localparam logic [1:0] CAPTURE = 2'd3;

   logic [W-1:0]  mem_a [DEPTH];
   logic [W-1:0]  mem_b [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [1:0]    state;
   logic [CW-1:0] wait_cnt;
   logic          add_en;
   logic [W-1:0]  add_a;
   logic [W-1:0]  add_b;
   logic          res_valid;
   logic [W-1:0]  res_sum;
   logic [7:0]    op_cnt;
   logic          full;
   logic          push;
   logic          pop;

   assign full = (count == (AW + 1)'(DEPTH));
   assign push = bus.in_valid && !full;
   assign pop  = (state == LAUNCH);

   assign bus.in_ready  = !full;
   assign bus.add_en    = add_en;
   assign bus.add_a     = add_a;
   assign bus.add_b     = add_b;
   assign bus.res_valid = res_valid;
   assign bus.res_sum   = res_sum;
   assign bus.busy      = (state != IDLE);
   assign bus.op_cnt    = op_cnt;

   // Storage needs no reset; the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_a[wr_ptr] <= bus.in_a;
         mem_b[wr_ptr] <= bus.in_b;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         state     <= IDLE;
         wait_cnt  <= '0;
         add_en    <= 1'b0;
         add_a     <= '0;
         add_b     <= '0;
         res_valid <= 1'b0;
         res_sum   <= '0;
         op_cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;

         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         add_en <= 1'b0;
         if (res_valid && bus.res_ready) res_valid <= 1'b0;

         unique case (state)
            IDLE: begin
               if (count != '0 && !res_valid) state <= LAUNCH;
            end
            LAUNCH: begin
               add_a    <= mem_a[rd_ptr];
               add_b    <= mem_b[rd_ptr];
               add_en   <= 1'b1;
               op_cnt   <= op_cnt + 8'd1;
               wait_cnt <= CW'(LATENCY - 1);
               state    <= WAIT;
            end
            WAIT: begin
               if (wait_cnt == '0) state <= CAPTURE;
               else wait_cnt <= wait_cnt - 1'b1;
            end
            CAPTURE: begin
               res_sum   <= bus.add_out;
               res_valid <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
